max_pool_3_ctrl: RTL and testbench
==================================

Name: max_pool_3_ctrl

Overview:
Sequencer that performs 2x2, stride-2 max pooling for the third pooling stage of the CNN accelerator.
- Reads the preceding conv-layer feature map from a source BRAM port.
- Computes the signed maximum of each 2x2 window.
- Writes each result into the max_pool_3 BRAM on port A.
- Started by the layer scheduler, which is notified on completion. The next layer reads the results through port B.

Parameters:
IN_H, 8, input feature-map height (even).
IN_W, 8, input feature-map width (even).
CHANNELS, 16, number of channels, stored channel-major.
DATA_W, 32, word width; BRAM data is signed two's complement.
SRC_BASE, 32'h0, byte base address of the source map.
DST_BASE, 32'h0, byte base address in max_pool_3 BRAM.

Ports:
clk  in  1  single clock for the block and both BRAM ports.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle request to begin a full pooling pass.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when the last result has been written.
src_addr  out  32  source BRAM byte address.
src_en  out  1  source read enable.
src_dout  in  32  source read data; valid 1 cycle after src_en.
dst_addr  out  32  max_pool_3 port-A byte address.
dst_din  out  32  pooled result.
dst_en  out  1  port-A enable.
dst_we  out  4  port-A byte write enables.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; busy, done, src_en, dst_en = 0; dst_we = 4'h0; src_addr, dst_addr, dst_din = 0; all counters = 0.
- Output grid: OUT_H = IN_H/2, OUT_W = IN_W/2. Loop order: channel c (outer), output row r, output column k (inner).
- Source address: SRC_BASE + 4*(c*IN_H*IN_W + y*IN_W + x), where (y,x) ranges over the window.
- Destination address: DST_BASE + 4*(c*OUT_H*OUT_W + r*OUT_W + k).
- FSM states:
  - IDLE: start=1 -> RD with counters cleared. start is ignored in every other state.
  - RD: 4 cycles, q=0..3. src_en=1. Window order is (2r,2k), (2r,2k+1), (2r+1,2k), (2r+1,2k+1).
  - WAIT: 1 cycle; the data for q=3 arrives.
  - WR: 1 cycle. dst_en=1, dst_we=4'hF, dst_din = registered window max.
    - Not last output: advance k, then r, then c, and go to RD.
    - Last output: go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Max accumulation:
  - The data from q=0 loads the accumulator.
  - The data from q=1..3 replaces it when src_dout > acc (signed compare).
  - On ties the accumulator keeps its value.
- Timing: 6 cycles per output. done asserts exactly 6*OUT_H*OUT_W*CHANNELS+1 cycles after the start cycle.
- Outside RD, src_en=0. Outside WR, dst_en=0 and dst_we=0. Address and data outputs hold their values when not enabled.
- Odd IN_H/IN_W: integer division; the last row/column is never read.
- Reset mid-pass: all outputs return to reset values immediately and no further writes occur. A partially written destination is left as-is.
- Overlapping start: start asserted in the DONE cycle is ignored; it is accepted in the following IDLE cycle.

Optional Feature:
Macro MAX_POOL_3_RELU_EN.
- Defined: a negative window max is replaced by 0 in WR (fused ReLU).
- Undefined: the signed max is written unchanged.
- Latency is identical in both builds.

Decomposition:
- Package max_pool_pkg holds:
  - the FSM state enum (IDLE, RD, WAIT, WR, DONE);
  - localparam WORD_BYTES=4;
  - the signed data typedef of width DATA_W;
  - the function computing byte addresses.
- Sub-module pool_window_max, the 4-input signed max accumulator: inputs load, update, din; output max.
- The controller holds the FSM, the counters and the address generation.

Test Plan:
- IN_H=IN_W=4, CHANNELS=2, source word i = i, start pulse:
  - 8 writes; channel-0 results 5, 7, 13, 15 at byte addresses 0x0, 0x4, 0x8, 0xC;
  - done exactly 49 cycles after start.
- Window {-7, -3, -9, -4}:
  - writes -3 (0xFFFFFFFD);
  - with MAX_POOL_3_RELU_EN defined, writes 0.
- All words equal 32'h7FFFFFFF: every write is 32'h7FFFFFFF (tie and extreme-value handling).
- start re-pulsed while busy, and again in the DONE cycle:
  - no restart and no extra writes;
  - a start one cycle after DONE begins a new pass.
- rst asserted at cycle 20 of a pass:
  - busy, src_en, dst_en and dst_we drop asynchronously;
  - a subsequent start produces a complete, correct pass.
- IN_H=IN_W=5, CHANNELS=1: 4 outputs; row 4 and column 4 are never addressed on src_addr.

Source files
------------

// File: rtl/max_pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : max_pool_pkg
// Description : Shared types and helpers for the max_pool_3 sequencer:
//               FSM state encoding, word size, signed data type and the
//               byte-address helper used by source and destination paths.
// Revision    : 1.0 - initial release
// ============================================================================
package max_pool_pkg;

  localparam int          POOL_DATA_W = 32;
  localparam logic [31:0] WORD_BYTES  = 32'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  typedef logic signed [POOL_DATA_W-1:0] data_t;

  // Word index -> byte address relative to a base.
  function automatic logic [31:0] byte_addr(input logic [31:0] base,
                                            input logic [31:0] word_idx);
    return base + word_idx * WORD_BYTES;
  endfunction

endpackage
`default_nettype wire

// File: rtl/max_pool_3_ctrl_window_max.sv
`default_nettype none
// ============================================================================
// Module      : pool_window_max
// Description : Signed running-max accumulator for one 2x2 pooling window.
//               load   : din replaces the accumulator (first window element)
//               update : din replaces the accumulator only if strictly greater
//               max    : current accumulator value
// Ports       : clk, rst (async, active-high), load, update, din -> max
// Revision    : 1.0 - initial release
// ============================================================================
module pool_window_max #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     update,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] max
);

  logic signed [DATA_W-1:0] max_q, max_d;

  // Ties keep the stored value: strictly-greater compare only.
  always_comb begin
    max_d = max_q;
    if (load)
      max_d = din;
    else if (update && (din > max_q))
      max_d = din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      max_q <= '0;
    else
      max_q <= max_d;
  end

  assign max = max_q;

endmodule
`default_nettype wire

// File: rtl/max_pool_3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : max_pool_3_ctrl
// Description : 2x2 stride-2 signed max-pooling sequencer. Reads a
//               channel-major feature map from a source BRAM, reduces each
//               window with pool_window_max and writes the result to BRAM
//               port A. Six cycles per output: RD x4, WAIT, WR.
// Ports       : clk, rst (async, active-high)
//               start -> busy, done          scheduler handshake
//               src_addr/src_en, src_dout    source read port (1-cycle latency)
//               dst_addr/dst_din/dst_en/dst_we  destination write port
// Options     : MAX_POOL_3_RELU_EN - when defined, negative window maxima are
//               written as 0 (fused ReLU). Latency is unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module max_pool_3_ctrl
  import max_pool_pkg::*;
#(
  parameter int          IN_H     = 8,
  parameter int          IN_W     = 8,
  parameter int          CHANNELS = 16,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] SRC_BASE = 32'h0,
  parameter logic [31:0] DST_BASE = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [31:0]       src_addr,
  output logic              src_en,
  input  logic [DATA_W-1:0] src_dout,
  output logic [31:0]       dst_addr,
  output logic [DATA_W-1:0] dst_din,
  output logic              dst_en,
  output logic [3:0]        dst_we
);

  localparam logic [31:0] OUT_H_L     = 32'(IN_H / 2);
  localparam logic [31:0] OUT_W_L     = 32'(IN_W / 2);
  localparam logic [31:0] IN_W_L      = 32'(IN_W);
  localparam logic [31:0] CH_L        = 32'(CHANNELS);
  localparam logic [31:0] PLANE_IN_L  = 32'(IN_H * IN_W);
  localparam logic [31:0] PLANE_OUT_L = 32'((IN_H / 2) * (IN_W / 2));

  state_e                   state_q, state_d;
  logic [31:0]              c_q, c_d, r_q, r_d, k_q, k_d;
  logic [1:0]               q_q, q_d;
  logic [31:0]              src_addr_q, src_addr_d;
  logic [31:0]              dst_addr_q, dst_addr_d;
  logic [DATA_W-1:0]        dst_din_q, dst_din_d;
  logic                     rd_vld_q, rd_vld_d;
  logic [1:0]               rd_idx_q, rd_idx_d;
  logic                     last_out;
  logic                     acc_load, acc_update;
  logic signed [DATA_W-1:0] win_max;
  logic signed [DATA_W-1:0] wr_data;

  assign last_out = (k_q == OUT_W_L - 32'd1) &&
                    (r_q == OUT_H_L - 32'd1) &&
                    (c_q == CH_L    - 32'd1);

  // --------------------------------------------------------------------------
  // Next-state and loop counters (k inner, then r, then c)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    k_d     = k_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD;
          c_d     = '0;
          r_d     = '0;
          k_d     = '0;
          q_d     = '0;
        end
      end
      RD: begin
        q_d = q_q + 2'd1;
        if (q_q == 2'd3)
          state_d = WAIT;
      end
      WAIT: state_d = WR;
      WR: begin
        if (last_out) begin
          state_d = DONE;
        end else begin
          state_d = RD;
          q_d     = '0;
          if (k_q == OUT_W_L - 32'd1) begin
            k_d = '0;
            if (r_q == OUT_H_L - 32'd1) begin
              r_d = '0;
              c_d = c_q + 32'd1;
            end else begin
              r_d = r_q + 32'd1;
            end
          end else begin
            k_d = k_q + 32'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Address generation. Addresses are registered from the next-cycle counters
  // so they line up with the enable and hold once the enable drops.
  // q[1] selects the window row, q[0] the window column.
  // --------------------------------------------------------------------------
  always_comb begin
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    if (state_d == RD)
      src_addr_d = byte_addr(SRC_BASE,
                             c_d * PLANE_IN_L +
                             (32'd2 * r_d + 32'(q_d[1])) * IN_W_L +
                             32'd2 * k_d + 32'(q_d[0]));
    if (state_d == WR)
      dst_addr_d = byte_addr(DST_BASE, c_q * PLANE_OUT_L + r_q * OUT_W_L + k_q);
  end

  // --------------------------------------------------------------------------
  // Read-data alignment: src_dout carries the word requested one cycle
  // earlier, so the read phase index is delayed by one cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_vld_d = (state_q == RD);
    rd_idx_d = q_q;
  end

  assign acc_load   = rd_vld_q && (rd_idx_q == 2'd0);
  assign acc_update = rd_vld_q && (rd_idx_q != 2'd0);

  pool_window_max #(
    .DATA_W (DATA_W)
  ) u_window_max (
    .clk    (clk),
    .rst    (rst),
    .load   (acc_load),
    .update (acc_update),
    .din    ($signed(src_dout)),
    .max    (win_max)
  );

`ifdef MAX_POOL_3_RELU_EN
  assign wr_data = win_max[DATA_W-1] ? '0 : win_max;
`else
  assign wr_data = win_max;
`endif

  // The last window word is only absorbed at the WAIT->WR edge, so the write
  // data is taken straight from the accumulator during WR and captured for
  // holding afterwards.
  assign dst_din   = (state_q == WR) ? wr_data : dst_din_q;
  assign dst_din_d = dst_din;

  // --------------------------------------------------------------------------
  // Control outputs decode the state register so that an asynchronous reset
  // drops them immediately.
  // --------------------------------------------------------------------------
  assign busy     = (state_q == RD) || (state_q == WAIT) || (state_q == WR);
  assign done     = (state_q == DONE);
  assign src_en   = (state_q == RD);
  assign dst_en   = (state_q == WR);
  assign dst_we   = (state_q == WR) ? 4'hF : 4'h0;
  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      c_q        <= '0;
      r_q        <= '0;
      k_q        <= '0;
      q_q        <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_din_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      r_q        <= r_d;
      k_q        <= k_d;
      q_q        <= q_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_din_q  <= dst_din_d;
      rd_vld_q   <= rd_vld_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max_pool_3_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_max_pool_3_ctrl
// Description : Scoreboard bench for max_pool_3_ctrl. Instance A is a 4x4x2
//               map, instance B a 5x5x1 map. Expected writes are queued by
//               the stimulus and popped by per-instance write monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_pool_3_ctrl;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A signals
  logic        start, busy, done, src_en, dst_en;
  logic [31:0] src_addr, src_dout, dst_addr, dst_din;
  logic [3:0]  dst_we;
  // Instance B signals
  logic        start_b, busy_b, done_b, src_en_b, dst_en_b;
  logic [31:0] src_addr_b, src_dout_b, dst_addr_b, dst_din_b;
  logic [3:0]  dst_we_b;

  logic [31:0] mem_a [0:31];
  logic [31:0] mem_b [0:31];
  wr_t         exp_a [$];
  wr_t         exp_b [$];

  max_pool_3_ctrl #(
    .IN_H(4), .IN_W(4), .CHANNELS(2), .DATA_W(32),
    .SRC_BASE(32'h0), .DST_BASE(32'h0)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .src_addr(src_addr), .src_en(src_en), .src_dout(src_dout),
    .dst_addr(dst_addr), .dst_din(dst_din), .dst_en(dst_en), .dst_we(dst_we)
  );

  max_pool_3_ctrl #(
    .IN_H(5), .IN_W(5), .CHANNELS(1), .DATA_W(32),
    .SRC_BASE(32'h0), .DST_BASE(32'h0)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .src_addr(src_addr_b), .src_en(src_en_b), .src_dout(src_dout_b),
    .dst_addr(dst_addr_b), .dst_din(dst_din_b), .dst_en(dst_en_b), .dst_we(dst_we_b)
  );

  // Source BRAM models: one-cycle read latency.
  always @(posedge clk) if (src_en)   src_dout   <= mem_a[src_addr[6:2]];
  always @(posedge clk) if (src_en_b) src_dout_b <= mem_b[src_addr_b[6:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitors
  wr_t ea, eb;
  always @(negedge clk) begin
    if (rst === 1'b0 && dst_en === 1'b1) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write_a: addr %h data %h", dst_addr, dst_din);
      end else begin
        ea = exp_a.pop_front();
        chk("wr_addr_a", dst_addr, ea.addr);
        chk("wr_data_a", dst_din, ea.data);
        chk("wr_we_a", {28'd0, dst_we}, 32'hF);
      end
    end
  end

  int wb;
  always @(negedge clk) begin
    if (rst === 1'b0 && dst_en_b === 1'b1) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write_b: addr %h data %h", dst_addr_b, dst_din_b);
      end else begin
        eb = exp_b.pop_front();
        chk("wr_addr_b", dst_addr_b, eb.addr);
        chk("wr_data_b", dst_din_b, eb.data);
      end
    end
    // Row 4 and column 4 of the 5x5 map must never be read.
    if (rst === 1'b0 && src_en_b === 1'b1) begin
      wb = int'(src_addr_b >> 2);
      total++;
      if (wb > 24 || (wb / 5) == 4 || (wb % 5) == 4) begin
        bad++;
        $display("FAIL src_b_range: word %0d read, required row<4 and col<4", wb);
      end
    end
  end

  // Waits for done with a cycle bound and checks its latency from start.
  task automatic wait_done(input bit sel, input int s, input int lat);
    bit seen = 1'b0;
    for (int i = 0; i < lat + 20 && !seen; i++) begin
      if ((sel ? done_b : done) === 1'b1) begin
        seen = 1'b1;
        chk("done_latency", 32'(cyc - s), 32'(lat));
        chk("busy_in_done", {31'd0, sel ? busy_b : busy}, 32'd0);
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) chk("done_seen", 32'd0, 32'd1);
    chk("queue_empty", 32'(sel ? exp_b.size() : exp_a.size()), 32'd0);
  endtask

  task automatic run_pass(input bit sel, input int lat);
    int s;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0; start_b = 1'b0;
    chk("busy_after_start", {31'd0, sel ? busy_b : busy}, 32'd1);
    wait_done(sel, s, lat);
  endtask

  // Ramp source (word i = i): window maxima 5,7,13,15 per channel, +16 for ch1.
  task automatic push_ramp();
    logic [31:0] v [4];
    v[0] = 32'd5; v[1] = 32'd7; v[2] = 32'd13; v[3] = 32'd15;
    for (int i = 0; i < 8; i++) begin
      wr_t e;
      e.addr = 32'(4 * i);
      e.data = v[i % 4] + 32'(16 * (i / 4));
      exp_a.push_back(e);
    end
  endtask

  task automatic push_const(input logic [31:0] d);
    for (int i = 0; i < 8; i++) begin
      wr_t e;
      e.addr = 32'(4 * i);
      e.data = d;
      exp_a.push_back(e);
    end
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 32; i++) mem_a[i] = 32'(i);
  endtask

  initial begin
    int s;
    logic [31:0] neg_exp;
    rst = 1'b1; start = 1'b0; start_b = 1'b0;
    fill_ramp();
    for (int i = 0; i < 32; i++) mem_b[i] = 32'(i);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy",     {31'd0, busy},   32'd0);
    chk("rst_done",     {31'd0, done},   32'd0);
    chk("rst_src_en",   {31'd0, src_en}, 32'd0);
    chk("rst_dst_en",   {31'd0, dst_en}, 32'd0);
    chk("rst_dst_we",   {28'd0, dst_we}, 32'd0);
    chk("rst_src_addr", src_addr, 32'd0);
    chk("rst_dst_addr", dst_addr, 32'd0);
    chk("rst_dst_din",  dst_din,  32'd0);
    rst = 1'b0;

    // Ramp pass
    push_ramp();
    run_pass(1'b0, 49);

    // Negative windows {-7,-3,-9,-4} everywhere
    for (int i = 0; i < 32; i++) begin
      case ({((i % 16) / 4) % 2 == 1, (i % 4) % 2 == 1})
        2'b00:   mem_a[i] = 32'hFFFF_FFF9;
        2'b01:   mem_a[i] = 32'hFFFF_FFFD;
        2'b10:   mem_a[i] = 32'hFFFF_FFF7;
        default: mem_a[i] = 32'hFFFF_FFFC;
      endcase
    end
`ifdef MAX_POOL_3_RELU_EN
    neg_exp = 32'h0000_0000;
`else
    neg_exp = 32'hFFFF_FFFD;
`endif
    push_const(neg_exp);
    run_pass(1'b0, 49);

    // All words at the positive extreme (ties everywhere)
    for (int i = 0; i < 32; i++) mem_a[i] = 32'h7FFF_FFFF;
    push_const(32'h7FFF_FFFF);
    run_pass(1'b0, 49);

    // Start re-pulsed while busy and in DONE: ignored.
    fill_ramp();
    push_ramp();
    @(negedge clk); start = 1'b1; s = cyc;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(1'b0, s, 49);
    start = 1'b1;                       // held through the DONE cycle edge
    @(negedge clk);
    start = 1'b0;
    chk("no_restart_from_done", {31'd0, busy}, 32'd0);
    push_ramp();
    start = 1'b1; s = cyc;              // IDLE cycle right after DONE
    @(negedge clk); start = 1'b0;
    chk("restart_after_done", {31'd0, busy}, 32'd1);
    wait_done(1'b0, s, 49);

    // Reset 20 cycles into a pass
    push_ramp();
    @(negedge clk); start = 1'b1; s = cyc;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 40 && cyc < s + 20; i++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",   {31'd0, busy},   32'd0);
    chk("arst_src_en", {31'd0, src_en}, 32'd0);
    chk("arst_dst_en", {31'd0, dst_en}, 32'd0);
    chk("arst_dst_we", {28'd0, dst_we}, 32'd0);
    exp_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);         // no writes may appear here
    push_ramp();
    run_pass(1'b0, 49);

    // 5x5x1 map: maxima 6,8,16,18; last row/column unused.
    for (int i = 0; i < 4; i++) begin
      wr_t e;
      e.addr = 32'(4 * i);
      e.data = 32'((i / 2) * 10 + (i % 2) * 2 + 6);
      exp_b.push_back(e);
    end
    run_pass(1'b1, 25);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
